icetap_spi_master: RTL and testbench

- Host-side SPI master that drives an icetap core's SPI scan port.
- Accepts one scan request at a time (chain select, bit count, write data) and runs one complete SPI transaction per request. Returns the bits captured on MISO.
- Sits in a host/bring-up FPGA or SoC. Intended as the single agent that configures masks, issues start commands and reads back status and recorded data.

---
 rtl/icetap_spi_master_pkg.sv | 28 ++
 rtl/icetap_spi_clkgen.sv | 36 +++
 rtl/icetap_spi_master.sv | 111 +++++++++++
 tb/tb_icetap_spi_master.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/icetap_spi_master_pkg.sv
// Shared constants and types for the icetap SPI master: chain-select codes,
// header width, SPI mode and the master FSM state encoding.
package icetap_spi_master_pkg;

  localparam int HDR_W    = 8;
  localparam int SPI_MODE = 0;

  localparam logic [7:0] CHAIN_CMD          = 8'h01;
  localparam logic [7:0] CHAIN_STATUS       = 8'h02;
  localparam logic [7:0] CHAIN_STORE_MASK   = 8'h03;
  localparam logic [7:0] CHAIN_TRIGGER_MASK = 8'h04;
  localparam logic [7:0] CHAIN_DATA         = 8'h05;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_HOLD,
    ST_GAP
  } state_t;

  // The header goes out MSB first while the frame register shifts right.
  function automatic logic [7:0] reverse8(input logic [7:0] b);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = b[7-i];
    return r;
  endfunction

endpackage

// File: rtl/icetap_spi_clkgen.sv
// Half-period divider: ticks on the last scan_clk cycle of every half-period
// and toggles the SPI clock level on each tick.
module icetap_spi_clkgen #(
  parameter int CLK_DIV = 2
) (
  input  logic scan_clk,
  input  logic scan_reset_,
  input  logic run,
  input  logic restart,
  output logic tick,
  output logic level
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] RELOAD = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt;

  assign tick = run && (cnt == '0);

  always_ff @(posedge scan_clk or negedge scan_reset_) begin
    if (!scan_reset_) begin
      cnt   <= RELOAD;
      level <= 1'b0;
    end else if (restart) begin
      cnt   <= RELOAD;
      level <= 1'b0;
    end else if (tick) begin
      cnt   <= RELOAD;
      level <= ~level;
    end else if (run) begin
      cnt   <= cnt - 1'b1;
    end
  end

endmodule

// File: rtl/icetap_spi_master.sv
// Host-side SPI master for the icetap scan port: one request in, one mode-0
// frame (8-bit chain header + payload) out, captured MISO payload back.
//
//   state  | meaning
//   IDLE   | ready for a request; rsp_valid pulses here after a frame
//   SHIFT  | ss_ low, clocking 8+len bits
//   HOLD   | one half-period with spi_clk low, ss_ still low
//   GAP    | one half-period with ss_ high before the next frame
module icetap_spi_master
  import icetap_spi_master_pkg::*;
#(
  parameter int CLK_DIV  = 2,
  parameter int MAX_BITS = 64,
  parameter int LEN_BITS = $clog2(MAX_BITS + 1)
) (
  input  logic                scan_clk,
  input  logic                scan_reset_,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [7:0]          req_chain,
  input  logic [LEN_BITS-1:0] req_len,
  input  logic [MAX_BITS-1:0] req_wdata,
  output logic                rsp_valid,
  output logic [MAX_BITS-1:0] rsp_rdata,
  output logic                busy,
  output logic                spi_clk,
  output logic                spi_ss_,
  output logic                spi_mosi,
  input  logic                spi_miso
);

  localparam int FW = HDR_W + MAX_BITS;
  localparam int BW = $clog2(FW + 1);
  localparam int PW = (MAX_BITS > 1) ? $clog2(MAX_BITS) : 1;

  state_t state, state_nx;

  logic [FW-1:0]       frame;
  logic [MAX_BITS-1:0] rx;
  logic [BW-1:0]       bit_idx, bit_total;
  logic [PW-1:0]       pidx;
  logic [LEN_BITS-1:0] len_c;
  logic                tick, level, accept, last_bit, high_tick;

  assign accept    = req_valid && req_ready;
  assign req_ready = (state == ST_IDLE);
  assign busy      = !req_ready;
  assign len_c     = (req_len > LEN_BITS'(MAX_BITS)) ? LEN_BITS'(MAX_BITS) : req_len;
  assign last_bit  = (bit_idx == bit_total - BW'(1));
  assign high_tick = (state == ST_SHIFT) && tick && level;
  assign pidx      = PW'(bit_idx - BW'(HDR_W));
  assign spi_clk   = level && (state == ST_SHIFT);
  assign spi_ss_   = !((state == ST_SHIFT) || (state == ST_HOLD));

  icetap_spi_clkgen #(.CLK_DIV(CLK_DIV)) u_clkgen (
    .scan_clk    (scan_clk),
    .scan_reset_ (scan_reset_),
    .run         (state != ST_IDLE),
    .restart     (accept),
    .tick        (tick),
    .level       (level)
  );

  always_ff @(posedge scan_clk or negedge scan_reset_) begin
    if (!scan_reset_) state <= ST_IDLE;
    else              state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:  if (accept) state_nx = ST_SHIFT;
      ST_SHIFT: if (high_tick && last_bit) state_nx = ST_HOLD;
      ST_HOLD:  if (tick) state_nx = ST_GAP;
      ST_GAP:   if (tick) state_nx = ST_IDLE;
      default:  state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge scan_clk or negedge scan_reset_) begin
    if (!scan_reset_) begin
      frame     <= '0;
      rx        <= '0;
      bit_idx   <= '0;
      bit_total <= '0;
      spi_mosi  <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      rsp_valid <= 1'b0;
      if (accept) begin
        frame     <= {req_wdata, reverse8(req_chain)};
        spi_mosi  <= req_chain[7];
        rx        <= '0;
        bit_idx   <= '0;
        bit_total <= BW'(HDR_W) + BW'(len_c);
      end else if (high_tick) begin
        // Header bits are clocked but their MISO is not kept.
        if (bit_idx >= BW'(HDR_W)) rx[pidx] <= spi_miso;
        frame    <= frame >> 1;
        spi_mosi <= last_bit ? 1'b0 : frame[1];
        bit_idx  <= bit_idx + BW'(1);
      end
      if ((state == ST_GAP) && tick) begin
        rsp_valid <= 1'b1;
        rsp_rdata <= rx;
      end
    end
  end

endmodule

// File: tb/tb_icetap_spi_master.sv
// Self-checking bench for icetap_spi_master: directed and random frames
// against a bit-list reference model and a simple mode-0 slave.
module tb_icetap_spi_master;

  localparam int CLK_DIV  = 2;
  localparam int MAX_BITS = 64;
  localparam int LEN_BITS = $clog2(MAX_BITS + 1);
  localparam int FB       = 8 + MAX_BITS;

  logic                scan_clk = 1'b0;
  logic                scan_reset_ = 1'b0;
  logic                req_valid = 1'b0;
  logic [7:0]          req_chain = '0;
  logic [LEN_BITS-1:0] req_len = '0;
  logic [MAX_BITS-1:0] req_wdata = '0;
  logic                spi_miso = 1'b0;
  logic                req_ready, rsp_valid, busy, spi_clk, spi_ss_, spi_mosi;
  logic [MAX_BITS-1:0] rsp_rdata;

  icetap_spi_master #(.CLK_DIV(CLK_DIV), .MAX_BITS(MAX_BITS), .LEN_BITS(LEN_BITS)) dut (
    .scan_clk(scan_clk), .scan_reset_(scan_reset_),
    .req_valid(req_valid), .req_ready(req_ready), .req_chain(req_chain),
    .req_len(req_len), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .busy(busy),
    .spi_clk(spi_clk), .spi_ss_(spi_ss_), .spi_mosi(spi_mosi), .spi_miso(spi_miso)
  );

  always #5 scan_clk = ~scan_clk;

  typedef struct {
    logic [7:0]          chain;
    int                  len;
    logic [MAX_BITS-1:0] wdata;
    logic [FB-1:0]       pat;
  } req_t;

  req_t req_q[$];

  int n_assert = 0, n_fail = 0;
  int cyc = 0;
  bit active = 0, noise = 0;
  int cur_t0, cur_n, rises, mosi_err, busy_err, hold_err, sl_idx;
  int ss_rise_cyc = 0, last_gap = 0, last_rsp_cyc = 0, b2b_stage = 0;
  logic [FB-1:0]       cur_pat = '0;
  logic                cur_mosi_exp[FB];
  logic [MAX_BITS-1:0] cur_exp, held_rdata = '0;
  logic                prev_clk = 1'b0, prev_ss = 1'b1;

  task automatic chk(input string tag, input logic [MAX_BITS-1:0] obs, input logic [MAX_BITS-1:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int len_eff(input int l);
    return (l > MAX_BITS) ? MAX_BITS : l;
  endfunction

  task automatic finish_txn();
    chk("rsp_only_when_active", {63'd0, active}, 64'd1);
    if (active) begin
      chk("latency", 64'(cyc), 64'(cur_t0 + 1 + CLK_DIV * (2 * cur_n + 2)));
      chk("rdata", rsp_rdata, cur_exp);
      chk("spi_clk_rises", 64'(rises), 64'(cur_n));
      chk("mosi_bit_errors", 64'(mosi_err), 64'd0);
      chk("busy_errors", 64'(busy_err), 64'd0);
      chk("ready_at_rsp", {63'd0, req_ready}, 64'd1);
    end
    active = 0;
    last_rsp_cyc = cyc;
    held_rdata = rsp_rdata;
  endtask

  task automatic accept_head();
    req_t r;
    r = req_q.pop_front();
    if (active) busy_err++;
    if (b2b_stage == 2) begin
      chk("b2b_accept_in_rsp_cycle", 64'(cyc), 64'(last_rsp_cyc));
      b2b_stage = 0;
    end else if (b2b_stage == 1) b2b_stage = 2;
    active = 1; cur_t0 = cyc; cur_n = 8 + len_eff(r.len);
    rises = 0; mosi_err = 0; busy_err = 0; cur_pat = r.pat; cur_exp = '0;
    for (int i = 0; i < cur_n; i++)
      cur_mosi_exp[i] = (i < 8) ? r.chain[7-i] : r.wdata[i-8];
    for (int p = 0; p < len_eff(r.len); p++) cur_exp[p] = r.pat[8+p];
  endtask

  task automatic drive();
    if (req_q.size() > 0) begin
      req_valid = 1'b1;
      req_chain = req_q[0].chain;
      req_len   = LEN_BITS'(req_q[0].len);
      req_wdata = req_q[0].wdata;
      if (req_ready === 1'b1) accept_head();
    end else if (noise && req_ready === 1'b0) begin
      req_valid = 1'($urandom_range(0, 1));
      req_chain = 8'($urandom);
      req_len   = LEN_BITS'($urandom);
      req_wdata = {$urandom, $urandom};
    end else begin
      req_valid = 1'b0;
    end
  endtask

  task automatic step();
    @(posedge scan_clk);
    cyc++;
    #1;
    if (prev_ss && !spi_ss_) begin
      sl_idx = 0; spi_miso = cur_pat[0]; last_gap = cyc - ss_rise_cyc;
    end else if (!spi_ss_ && prev_clk && !spi_clk) begin
      sl_idx++; spi_miso = (sl_idx < FB) ? cur_pat[sl_idx] : 1'b0;
    end
    if (!prev_ss && spi_ss_) ss_rise_cyc = cyc;
    if (!prev_clk && spi_clk) begin
      if (active && rises < FB && spi_mosi !== cur_mosi_exp[rises]) mosi_err++;
      rises++;
    end
    if (active && cyc > cur_t0 && !rsp_valid && busy !== 1'b1) busy_err++;
    if (active && cyc == cur_t0 + 1) chk("ss_falls_t0_plus_1", {63'd0, spi_ss_}, 64'd0);
    if (!rsp_valid && rsp_rdata !== held_rdata) hold_err++;
    if (rsp_valid) finish_txn();
    prev_clk = spi_clk; prev_ss = spi_ss_;
    drive();
  endtask

  task automatic push(input logic [7:0] chain, input int len, input logic [MAX_BITS-1:0] wdata,
                      input logic [FB-1:0] pat);
    req_t r;
    r.chain = chain; r.len = len; r.wdata = wdata; r.pat = pat;
    req_q.push_back(r);
  endtask

  task automatic run_until_idle(input int budget);
    int k = 0;
    while ((req_q.size() > 0 || active) && k < budget) begin
      step();
      k++;
    end
    chk("completed_within_budget", {63'd0, k < budget}, 64'd1);
    req_q.delete();
    noise = 0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_ss"}, {63'd0, spi_ss_}, 64'd1);
    chk({tag, "_clk"}, {63'd0, spi_clk}, 64'd0);
    chk({tag, "_mosi"}, {63'd0, spi_mosi}, 64'd0);
    chk({tag, "_busy"}, {63'd0, busy}, 64'd0);
    chk({tag, "_ready"}, {63'd0, req_ready}, 64'd1);
    chk({tag, "_rsp_valid"}, {63'd0, rsp_valid}, 64'd0);
    chk({tag, "_rdata"}, rsp_rdata, 64'd0);
  endtask

  function automatic logic [FB-1:0] rnd_pat();
    return {$urandom, $urandom, $urandom};
  endfunction

  initial begin
    logic [FB-1:0] p;
    int k;

    step(); step();
    chk_reset_outputs("reset");
    scan_reset_ = 1'b1;
    for (int i = 0; i < 100; i++) step();
    chk_reset_outputs("idle100");

    push(8'h01, 8, 64'hA5, rnd_pat());
    run_until_idle(400);

    p = rnd_pat();
    p[23:8] = 16'hBEEF;
    push(8'h05, 16, {$urandom, $urandom}, p);
    run_until_idle(400);
    chk("beef_rdata", rsp_rdata, 64'h0000_0000_0000_BEEF);

    push(8'h02, 0, {$urandom, $urandom}, rnd_pat());
    run_until_idle(400);

    push(8'h05, 70, {$urandom, $urandom}, rnd_pat());
    run_until_idle(800);

    b2b_stage = 1;
    noise = 1;
    push(8'h03, 12, {$urandom, $urandom}, rnd_pat());
    push(8'h04, 5, {$urandom, $urandom}, rnd_pat());
    run_until_idle(800);
    chk("b2b_ss_gap_ge_half_period", {63'd0, last_gap >= CLK_DIV}, 64'd1);
    chk("b2b_second_accepted", 64'(b2b_stage), 64'd0);

    noise = 1;
    for (int i = 0; i < 8; i++)
      push(8'($urandom), int'($urandom_range(0, 70)), {$urandom, $urandom}, rnd_pat());
    run_until_idle(4000);

    push(8'h05, 32, {$urandom, $urandom}, rnd_pat());
    k = 0;
    while (!(active && rises >= 8 + 12) && k < 400) begin
      step();
      k++;
    end
    chk("reached_payload_bit_12", {63'd0, k < 400}, 64'd1);
    scan_reset_ = 1'b0;
    #1;
    chk_reset_outputs("midreset");
    active = 0; req_q.delete(); req_valid = 1'b0; held_rdata = '0;
    step(); step();
    scan_reset_ = 1'b1;
    for (int i = 0; i < 20; i++) step();
    chk("midreset_still_idle", {63'd0, req_ready}, 64'd1);

    push(8'h01, 32, {$urandom, $urandom}, rnd_pat());
    run_until_idle(600);

    chk("rdata_hold_errors", 64'(hold_err), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
